// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encodings and default constants for the stopwatch controller.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LAP    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_CLEAR  = 3'd4
  } sw_state_e;

  localparam int DEF_BITS       = 29;
  localparam int DEF_MAX_COUNT  = 359999999;  // 99:59:59.999 in ms
  localparam int DEF_DEB_CYCLES = 20;         // 20 ms at 1 kHz

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
// The accepted level only changes after DEB_CYCLES consecutive synchronized
// samples disagree with it, so both press and release must be stable.
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic NEclk,
  input  logic Nreset,
  input  logic raw,
  output logic press_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          pulse_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous button into the clock domain.
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count disagreeing samples; accept the new level after DEB_CYCLES of them
  // and emit a one-cycle pulse when the newly accepted level is "pressed".
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else if (sync2_reg == level_reg) begin
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else if (cnt_reg == LAST) begin
      level_reg <= sync2_reg;
      cnt_reg   <= '0;
      pulse_reg <= sync2_reg;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
      pulse_reg <= 1'b0;
    end
  end

  assign press_pulse = pulse_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced START/STOP and LAP/RESET buttons drive the
// counter enable/clear, lap capture, display select and ceiling detection.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            btn_ss_raw,
  input  logic            btn_lr_raw,
  input  logic [BITS-1:0] count,
  output logic            cnt_enable,
  output logic            cnt_nclr,
  output logic            disp_lap,
  output logic [BITS-1:0] lap_count,
  output logic            overflow,
  output logic [2:0]      state
);

  localparam logic [BITS-1:0] MAX_VAL = BITS'(MAX_COUNT);

  logic            ss_pulse;
  logic            lr_pulse;
  logic            at_max;
  logic            capture;
  logic            set_ovf;
  sw_state_e       state_reg;
  sw_state_e       state_next;
  logic            cnt_enable_reg;
  logic            cnt_nclr_reg;
  logic            disp_lap_reg;
  logic [BITS-1:0] lap_count_reg;
  logic            overflow_reg;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .NEclk       (NEclk),
    .Nreset      (Nreset),
    .raw         (btn_ss_raw),
    .press_pulse (ss_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .NEclk       (NEclk),
    .Nreset      (Nreset),
    .raw         (btn_lr_raw),
    .press_pulse (lr_pulse)
  );

  // A count beyond the ceiling is treated as sitting on it.
  assign at_max = (count >= MAX_VAL);

  // Next-state selection: ceiling beats buttons, START/STOP beats LAP/RESET.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    set_ovf    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_pulse) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (at_max) begin
          state_next = ST_PAUSED;
          set_ovf    = 1'b1;
        end else if (ss_pulse) begin
          state_next = ST_PAUSED;
        end else if (lr_pulse) begin
          state_next = ST_LAP;
          capture    = 1'b1;
        end
      end
      ST_LAP: begin
        if (at_max) begin
          state_next = ST_PAUSED;
          set_ovf    = 1'b1;
        end else if (ss_pulse) begin
          state_next = ST_PAUSED;
        end else if (lr_pulse) begin
          state_next = ST_RUN;
        end
      end
      ST_PAUSED: begin
        // After hitting the ceiling only a reset may leave PAUSED.
        if (ss_pulse && !overflow_reg) state_next = ST_RUN;
        else if (lr_pulse)             state_next = ST_CLEAR;
      end
      ST_CLEAR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State and outputs are registered from the next state.
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      state_reg      <= ST_IDLE;
      cnt_enable_reg <= 1'b0;
      cnt_nclr_reg   <= 1'b0;
      disp_lap_reg   <= 1'b0;
      lap_count_reg  <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_enable_reg <= (state_next == ST_RUN) || (state_next == ST_LAP);
      cnt_nclr_reg   <= (state_next != ST_CLEAR);
      disp_lap_reg   <= (state_next == ST_LAP);
      if (state_next == ST_CLEAR) begin
        lap_count_reg <= '0;
        overflow_reg  <= 1'b0;
      end else begin
        if (capture) lap_count_reg <= count;
        if (set_ovf) overflow_reg  <= 1'b1;
      end
    end
  end

  assign cnt_enable = cnt_enable_reg;
  assign cnt_nclr   = cnt_nclr_reg;
  assign disp_lap   = disp_lap_reg;
  assign lap_count  = lap_count_reg;
  assign overflow   = overflow_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4.
module tb_stopwatch_ctrl;

  localparam int BITS = 29;
  localparam int MAXC = 359999999;

  logic            NEclk = 1'b0;
  logic            Nreset;
  logic            btn_ss_raw;
  logic            btn_lr_raw;
  logic [BITS-1:0] count;
  logic            cnt_enable;
  logic            cnt_nclr;
  logic            disp_lap;
  logic [BITS-1:0] lap_count;
  logic            overflow;
  logic [2:0]      state;

  int n_cmp = 0;
  int n_bad = 0;
  int ss_pulses = 0;

  stopwatch_ctrl #(.BITS(BITS), .MAX_COUNT(MAXC), .DEB_CYCLES(4)) u_dut (
    .NEclk      (NEclk),
    .Nreset     (Nreset),
    .btn_ss_raw (btn_ss_raw),
    .btn_lr_raw (btn_lr_raw),
    .count      (count),
    .cnt_enable (cnt_enable),
    .cnt_nclr   (cnt_nclr),
    .disp_lap   (disp_lap),
    .lap_count  (lap_count),
    .overflow   (overflow),
    .state      (state)
  );

  always #5 NEclk = ~NEclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one active (falling) edge, then settle 1 time unit.
  task automatic tick();
    @(negedge NEclk);
    #1;
    if (u_dut.u_deb_ss.press_pulse) ss_pulses++;
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) tick();
  endtask

  // Press the selected buttons and return while the debounced pulse is high.
  task automatic press(input logic ss, input logic lr);
    bit hit;
    hit = 1'b0;
    btn_ss_raw = ss;
    btn_lr_raw = lr;
    for (int n = 0; n < 20 && !hit; n++) begin
      tick();
      if (u_dut.u_deb_ss.press_pulse || u_dut.u_deb_lr.press_pulse) hit = 1'b1;
    end
    check("press_seen", 32'(hit), 32'd1);
    btn_ss_raw = 1'b0;
    btn_lr_raw = 1'b0;
  endtask

  initial begin
    int pulse_k;
    Nreset = 1'b0; btn_ss_raw = 1'b0; btn_lr_raw = 1'b0; count = '0;
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_nclr", 32'(cnt_nclr), 32'd0);
    check("rst_en", 32'(cnt_enable), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    Nreset = 1'b1;
    tick();
    check("rel_nclr", 32'(cnt_nclr), 32'd1);
    check("rel_state", 32'(state), 32'd0);

    // Debounce: bouncing input, then held high.
    ss_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      btn_ss_raw = (i % 2 == 0);
      tick();
    end
    btn_ss_raw = 1'b1;
    pulse_k = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (u_dut.u_deb_ss.press_pulse && pulse_k == 0) pulse_k = k;
      if (k == 6) check("deb_still_idle", 32'(state), 32'd0);
    end
    check("deb_pulse_tick", 32'(pulse_k), 32'd6);
    check("deb_state_run", 32'(state), 32'd1);
    check("deb_en", 32'(cnt_enable), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    check("deb_one_pulse", 32'(ss_pulses), 32'd1);
    btn_ss_raw = 1'b0;
    settle();
    check("deb_hold_run", 32'(state), 32'd1);

    // Lap capture and release.
    count = 5000;
    press(1'b0, 1'b1); tick();
    check("lap_state", 32'(state), 32'd2);
    check("lap_val", 32'(lap_count), 32'd5000);
    check("lap_disp", 32'(disp_lap), 32'd1);
    check("lap_en", 32'(cnt_enable), 32'd1);
    settle();
    count = 6000;
    press(1'b0, 1'b1); tick();
    check("unlap_state", 32'(state), 32'd1);
    check("unlap_disp", 32'(disp_lap), 32'd0);
    check("unlap_val", 32'(lap_count), 32'd5000);
    settle();

    // Pause, then clear.
    press(1'b1, 1'b0); tick();
    check("pause_state", 32'(state), 32'd3);
    check("pause_en", 32'(cnt_enable), 32'd0);
    settle();
    press(1'b0, 1'b1); tick();
    check("clr_state", 32'(state), 32'd4);
    check("clr_nclr", 32'(cnt_nclr), 32'd0);
    check("clr_lap", 32'(lap_count), 32'd0);
    tick();
    check("clr_idle", 32'(state), 32'd0);
    check("clr_nclr_back", 32'(cnt_nclr), 32'd1);
    settle();

    // Simultaneous pulses in RUN: START/STOP wins.
    press(1'b1, 1'b0); tick(); settle();
    count = 7000;
    press(1'b0, 1'b1); tick(); settle();
    press(1'b0, 1'b1); tick(); settle();
    check("sim_pre_run", 32'(state), 32'd1);
    count = 8000;
    press(1'b1, 1'b1); tick();
    check("sim_state", 32'(state), 32'd3);
    check("sim_lap", 32'(lap_count), 32'd7000);
    check("sim_disp", 32'(disp_lap), 32'd0);
    settle();

    // Ceiling reached while running.
    press(1'b1, 1'b0); tick(); settle();
    check("ovf_pre_run", 32'(state), 32'd1);
    count = BITS'(MAXC);
    tick();
    check("ovf_state", 32'(state), 32'd3);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_en", 32'(cnt_enable), 32'd0);
    press(1'b1, 1'b0); tick();
    check("ovf_ss_ignored", 32'(state), 32'd3);
    settle();
    press(1'b0, 1'b1); tick();
    check("ovf_clr_state", 32'(state), 32'd4);
    check("ovf_clr_flag", 32'(overflow), 32'd0);
    tick();
    check("ovf_idle", 32'(state), 32'd0);
    settle();

    // Asynchronous reset in the middle of a lap.
    count = 1234;
    press(1'b1, 1'b0); tick(); settle();
    press(1'b0, 1'b1); tick(); settle();
    check("mid_lap_val", 32'(lap_count), 32'd1234);
    Nreset = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_en", 32'(cnt_enable), 32'd0);
    check("arst_nclr", 32'(cnt_nclr), 32'd0);
    check("arst_disp", 32'(disp_lap), 32'd0);
    check("arst_lap", 32'(lap_count), 32'd0);
    tick();
    Nreset = 1'b1;
    tick();
    check("arst_rel_nclr", 32'(cnt_nclr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
